// File: rtl/noise_table_reader.sv
// noise_table_reader: fetches word_count consecutive 64-bit words from the
// noise-probability RAM (fixed latency, no waitrequest) and streams them out
// in order through a small first-word-fall-through FIFO. Reads are issued
// only when the FIFO has room for every word already in flight.
module noise_table_reader #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 64,
  parameter int BE_W         = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FL_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       addr_reg, addr_next;
  logic [ADDR_W-1:0]       remaining_reg, remaining_next;
  logic [FL_W-1:0]         flush_cnt_reg, flush_cnt_next;
  logic [READ_LATENCY-1:0] vld_reg, vld_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic             fifo_clear;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   credit_sum;
  logic             credit_ok;

  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;
  assign avm_address    = addr_reg;
  assign avm_chipselect = issue;
  assign busy           = (state_reg != S_IDLE);
  assign done           = (state_reg == S_DONE);
  assign out_valid      = (count_reg != '0);
  assign out_data       = out_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign pop            = out_valid && out_ready;
  // Returns arriving while flushing belong to the cancelled burst.
  assign push           = vld_reg[READ_LATENCY-1] && (state_reg != S_FLUSH);

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_reg[i]);
    end
  end

  assign credit_sum = {1'b0, count_reg} + {1'b0, inflight};
  assign credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);

  // Shift a marker through the latency pipe for every issued read.
  always_comb begin
    vld_next    = vld_reg << 1;
    vld_next[0] = issue;
  end

  // Next-state, issue and flush decisions.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    flush_cnt_next = flush_cnt_reg;
    issue          = 1'b0;
    fifo_clear     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          addr_next      = base_addr;
          remaining_next = word_count;
          state_next     = (word_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        issue = (remaining_reg != '0) && credit_ok;
        if (issue) begin
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - ADDR_W'(1);
        end
        if (abort) begin
          state_next     = S_FLUSH;
          fifo_clear     = 1'b1;
          flush_cnt_next = '0;
        end else if (issue && (remaining_reg == ADDR_W'(1))) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_next     = S_FLUSH;
          fifo_clear     = 1'b1;
          flush_cnt_next = '0;
        end else if ((vld_reg == '0) &&
                     ((count_reg == '0) || ((count_reg == CNT_W'(1)) && pop))) begin
          state_next = S_DONE;
        end
      end
      S_FLUSH: begin
        // Wait out every read issued up to the abort cycle.
        if (flush_cnt_reg == FL_W'(READ_LATENCY - 1)) begin
          state_next = S_DONE;
        end else begin
          flush_cnt_next = flush_cnt_reg + FL_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control registers and read-latency tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      flush_cnt_reg <= '0;
      vld_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      flush_cnt_reg <= flush_cnt_next;
      vld_reg       <= vld_next;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (fifo_clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage; contents need no reset because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= avm_readdata;
  end

endmodule
